// File: rtl/swing_detector.sv
// swing_detector: turns per-frame saber centroids into discrete swing events.
// A three-stage pipeline: stage 0 takes frame deltas, stage 1 classifies the
// motion (speed, direction, glitch), stage 2 runs the swing FSM.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   frame_start, x_in, y_in new centroid strobe and coordinates
//   dx, dy                  signed deltas of the last evaluated frame
//   glitch                  last evaluated frame exceeded the jump limit
//   in_swing                FSM currently tracking a swing
//   swing                   one-cycle pulse when a swing completes
//   swing_dir, swing_speed  direction and peak speed of the last swing
module swing_detector #(
    parameter int unsigned SPEED_THRESH     = 24,
    parameter int unsigned MIN_SWING_FRAMES = 2,
    parameter int unsigned COOLDOWN_FRAMES  = 15,
    parameter int unsigned MAX_JUMP         = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [10:0] x_in,
    input  logic [10:0] y_in,
    output logic [11:0] dx,
    output logic [11:0] dy,
    output logic        glitch,
    output logic        in_swing,
    output logic        swing,
    output logic [1:0]  swing_dir,
    output logic [11:0] swing_speed
);

    localparam int unsigned XW      = 11;
    localparam int unsigned DW      = 12;
    localparam int unsigned RUN_W   = 4;
    localparam int unsigned RUN_MAX = 15;
    localparam int unsigned CD_W    = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

    localparam logic [1:0] S_INIT     = 2'd0;
    localparam logic [1:0] S_IDLE     = 2'd1;
    localparam logic [1:0] S_SWING    = 2'd2;
    localparam logic [1:0] S_COOLDOWN = 2'd3;

    logic [XW-1:0]    x_prev, y_prev;
    logic             v1, v2;
    logic [DW-1:0]    spd1;
    logic [1:0]       dir1;
    logic             fast1;

    logic [1:0]       state, state_nxt;
    logic [RUN_W-1:0] run, run_nxt;
    logic [1:0]       cur_dir, cur_dir_nxt;
    logic [DW-1:0]    peak, peak_nxt;
    logic [CD_W-1:0]  cd, cd_nxt;
    logic             swing_nxt;
    logic [1:0]       swing_dir_nxt;
    logic [DW-1:0]    swing_speed_nxt;

    // Stage 1 classification of the registered deltas
    logic [XW-1:0] ax_c, ay_c;
    logic [DW-1:0] spd_c;
    logic          glitch_c, fast_c;
    logic [1:0]    dir_c;

    assign ax_c     = dx[DW-1] ? XW'(-dx) : dx[XW-1:0];
    assign ay_c     = dy[DW-1] ? XW'(-dy) : dy[XW-1:0];
    assign spd_c    = DW'(ax_c) + DW'(ay_c);
    assign glitch_c = (ax_c > XW'(MAX_JUMP)) || (ay_c > XW'(MAX_JUMP));
    assign fast_c   = (spd_c >= DW'(SPEED_THRESH)) && !glitch_c;
    // Ties between |dx| and |dy| resolve to the horizontal axis
    assign dir_c    = (ax_c >= ay_c) ? (dx[DW-1] ? 2'd1 : 2'd0)
                                     : (dy[DW-1] ? 2'd3 : 2'd2);

    assign in_swing = (state == S_SWING);

    // Stage 0 / stage 1 datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            x_prev <= '0;
            y_prev <= '0;
            dx     <= '0;
            dy     <= '0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            glitch <= 1'b0;
            spd1   <= '0;
            dir1   <= '0;
            fast1  <= 1'b0;
        end else begin
            v1 <= 1'b0;
            v2 <= v1;
            if (frame_start) begin
                x_prev <= x_in;
                y_prev <= y_in;
                if (state != S_INIT) begin
                    dx <= {1'b0, x_in} - {1'b0, x_prev};
                    dy <= {1'b0, y_in} - {1'b0, y_prev};
                    v1 <= 1'b1;
                end else begin
                    dx <= '0;
                    dy <= '0;
                end
            end
            if (v1) begin
                glitch <= glitch_c;
                spd1   <= spd_c;
                dir1   <= dir_c;
                fast1  <= fast_c;
            end
        end
    end

    // Stage 2 FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_INIT;
            run         <= '0;
            cur_dir     <= '0;
            peak        <= '0;
            cd          <= '0;
            swing       <= 1'b0;
            swing_dir   <= '0;
            swing_speed <= '0;
        end else begin
            state       <= state_nxt;
            run         <= run_nxt;
            cur_dir     <= cur_dir_nxt;
            peak        <= peak_nxt;
            cd          <= cd_nxt;
            swing       <= swing_nxt;
            swing_dir   <= swing_dir_nxt;
            swing_speed <= swing_speed_nxt;
        end
    end

    // Stage 2 next-state logic; the first frame after reset only leaves INIT
    always_comb begin
        state_nxt       = state;
        run_nxt         = run;
        cur_dir_nxt     = cur_dir;
        peak_nxt        = peak;
        cd_nxt          = cd;
        swing_nxt       = 1'b0;
        swing_dir_nxt   = swing_dir;
        swing_speed_nxt = swing_speed;
        if (state == S_INIT) begin
            if (frame_start) begin
                state_nxt = S_IDLE;
            end
        end else if (v2) begin
            case (state)
                S_IDLE: begin
                    if (fast1) begin
                        state_nxt   = S_SWING;
                        run_nxt     = RUN_W'(1);
                        cur_dir_nxt = dir1;
                        peak_nxt    = spd1;
                    end
                end
                S_SWING: begin
                    if (fast1 && (dir1 == cur_dir)) begin
                        if (run != RUN_W'(RUN_MAX)) begin
                            run_nxt = run + RUN_W'(1);
                        end
                        if (spd1 > peak) begin
                            peak_nxt = spd1;
                        end
                    end else if (fast1) begin
                        run_nxt     = RUN_W'(1);
                        cur_dir_nxt = dir1;
                        peak_nxt    = spd1;
                    end else if (run >= RUN_W'(MIN_SWING_FRAMES)) begin
                        swing_nxt       = 1'b1;
                        swing_dir_nxt   = cur_dir;
                        swing_speed_nxt = peak;
                        cd_nxt          = CD_W'(COOLDOWN_FRAMES);
                        state_nxt       = (COOLDOWN_FRAMES != 0) ? S_COOLDOWN : S_IDLE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
                S_COOLDOWN: begin
                    // Motion is ignored; only the frame count matters here
                    cd_nxt = cd - CD_W'(1);
                    if (cd <= CD_W'(1)) begin
                        cd_nxt    = '0;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_swing_detector.sv
// Randomized scoreboard bench for swing_detector: a frame-level reference model
// predicts each frame's outcome when the frame is issued; a monitor follows each
// frame through the pipeline and compares the DUT outputs at each stage.
module tb_swing_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [10:0] x_in, y_in;
    logic [11:0] dx, dy;
    logic        glitch, in_swing, swing;
    logic [1:0]  swing_dir;
    logic [11:0] swing_speed;

    swing_detector dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .x_in        (x_in),
        .y_in        (y_in),
        .dx          (dx),
        .dy          (dy),
        .glitch      (glitch),
        .in_swing    (in_swing),
        .swing       (swing),
        .swing_dir   (swing_dir),
        .swing_speed (swing_speed)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        eval;
        logic [11:0] dx;
        logic [11:0] dy;
        logic        glitch;
        logic        in_swing;
        logic        swing;
        logic [1:0]  dir;
        logic [11:0] spd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   swings_seen = 0;

    // Reference model: frame-level behaviour of the detector
    bit m_started;
    int m_px, m_py;
    int m_mode;            // 0 idle, 1 tracking a swing, 2 cooling down
    int m_run, m_cdir, m_peak, m_cd;
    int m_ldir, m_lspd;

    function automatic void model_reset();
        m_started = 0; m_px = 0; m_py = 0; m_mode = 0;
        m_run = 0; m_cdir = 0; m_peak = 0; m_cd = 0;
        m_ldir = 0; m_lspd = 0;
    endfunction

    function automatic exp_t model_frame(int x, int y);
        exp_t e;
        int ddx, ddy, ax, ay, spd, dir;
        bit g, fast, pulse;
        e.eval = 0; e.dx = '0; e.dy = '0; e.glitch = 0; e.in_swing = 0;
        e.swing = 0; e.dir = '0; e.spd = '0;
        if (!m_started) begin
            m_started = 1; m_px = x; m_py = y;
            return e;
        end
        ddx = x - m_px; ddy = y - m_py;
        m_px = x; m_py = y;
        ax = (ddx < 0) ? -ddx : ddx;
        ay = (ddy < 0) ? -ddy : ddy;
        spd = ax + ay;
        g = (ax > 256) || (ay > 256);
        fast = (spd >= 24) && !g;
        if (ax >= ay) dir = (ddx >= 0) ? 0 : 1;
        else          dir = (ddy >= 0) ? 2 : 3;
        pulse = 0;
        if (m_mode == 0) begin
            if (fast) begin m_mode = 1; m_run = 1; m_cdir = dir; m_peak = spd; end
        end else if (m_mode == 1) begin
            if (fast && dir == m_cdir) begin
                m_run = (m_run < 15) ? m_run + 1 : 15;
                if (spd > m_peak) m_peak = spd;
            end else if (fast) begin
                m_run = 1; m_cdir = dir; m_peak = spd;
            end else if (m_run >= 2) begin
                pulse = 1; m_ldir = m_cdir; m_lspd = m_peak;
                m_mode = 2; m_cd = 15;
            end else begin
                m_mode = 0;
            end
        end else begin
            m_cd--;
            if (m_cd == 0) m_mode = 0;
        end
        e.eval = 1; e.dx = 12'(ddx); e.dy = 12'(ddy); e.glitch = g;
        e.in_swing = (m_mode == 1); e.swing = pulse;
        e.dir = 2'(m_ldir); e.spd = 12'(m_lspd);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: follows each frame through stages 0..2 and checks its outputs
    always begin : monitor
        logic fs, rs;
        exp_t s0, s1, s2;
        bit v0, v1, v2;
        v0 = 0; v1 = 0; v2 = 0;
        forever begin
            @(posedge clock);
            fs = frame_start;
            rs = reset;
            #1;
            if (rs) begin
                v0 = 0; v1 = 0; v2 = 0;
                chk("rst_dx", 32'(dx), 0);
                chk("rst_dy", 32'(dy), 0);
                chk("rst_glitch", 32'(glitch), 0);
                chk("rst_in_swing", 32'(in_swing), 0);
                chk("rst_swing", 32'(swing), 0);
                chk("rst_swing_dir", 32'(swing_dir), 0);
                chk("rst_swing_speed", 32'(swing_speed), 0);
            end else begin
                s2 = s1; v2 = v1;
                s1 = s0; v1 = v0;
                v0 = 0;
                if (fs) begin
                    if (exp_q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL scoreboard: frame seen with no expectation at %0t", $time);
                    end else begin
                        s0 = exp_q.pop_front();
                        v0 = 1;
                    end
                end
                if (v0) begin
                    chk("dx", 32'(dx), 32'(s0.dx));
                    chk("dy", 32'(dy), 32'(s0.dy));
                end
                if (v1 && s1.eval) chk("glitch", 32'(glitch), 32'(s1.glitch));
                if (v2 && s2.eval) begin
                    chk("in_swing", 32'(in_swing), 32'(s2.in_swing));
                    chk("swing", 32'(swing), 32'(s2.swing));
                    chk("swing_dir", 32'(swing_dir), 32'(s2.dir));
                    chk("swing_speed", 32'(swing_speed), 32'(s2.spd));
                    if (s2.swing) swings_seen++;
                end else begin
                    chk("swing_idle", 32'(swing), 0);
                end
            end
        end
    end

    // Driver: called at a falling edge, returns at a falling edge
    task automatic send(input int x, input int y, input int gap);
        exp_t e;
        frame_start = 1'b1;
        x_in = 11'(x);
        y_in = 11'(y);
        e = model_frame(x, y);
        exp_q.push_back(e);
        @(negedge clock);
        frame_start = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic do_reset(input bit with_frame);
        reset = 1'b1;
        frame_start = with_frame;
        x_in = 11'd500;
        y_in = 11'd500;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        frame_start = 1'b0;
        @(negedge clock);
    endtask

    function automatic int clampc(int v);
        return (v < 0) ? 0 : ((v > 2047) ? 2047 : v);
    endfunction

    int cx, cy;

    initial begin
        reset = 1'b1; frame_start = 1'b0; x_in = '0; y_in = '0;
        model_reset();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Stationary saber
        for (int i = 0; i < 10; i++) send(100, 100, 1);
        // Rightward swing, speed 30
        send(130, 100, 0); send(160, 100, 0); send(190, 100, 0);
        for (int i = 0; i < 18; i++) send(190, 100, 1);
        // Upward swing, speed 40
        send(190, 300, 1); send(190, 260, 1); send(190, 220, 1);
        for (int i = 0; i < 18; i++) send(190, 220, 2);
        // Single fast frame is not a swing
        send(240, 220, 0);
        for (int i = 0; i < 3; i++) send(240, 220, 0);
        // Glitch jump then a normal frame
        send(100, 220, 1); send(500, 220, 1); send(500, 220, 1); send(510, 220, 1);
        for (int i = 0; i < 3; i++) send(510, 220, 0);
        // Cooldown: second swing ignored, third reported
        send(540, 220, 0); send(570, 220, 0); send(570, 220, 0);
        for (int i = 0; i < 4; i++) send(570, 220, 0);
        send(600, 220, 0); send(630, 220, 0); send(630, 220, 0);
        for (int i = 0; i < 16; i++) send(630, 220, 0);
        send(600, 220, 0); send(570, 220, 0); send(570, 220, 0);
        for (int i = 0; i < 16; i++) send(570, 220, 0);

        // Reset with a simultaneous frame_start
        do_reset(1'b1);
        cx = 1000; cy = 1000;
        send(cx, cy, 1);

        // Random motion segments
        for (int seg = 0; seg < 80; seg++) begin
            int kind, len, vx, vy;
            kind = int'($urandom_range(0, 4));
            len  = int'($urandom_range(1, 5));
            case (kind)
                0: begin vx = 0; vy = 0; end
                1: begin
                    vx = int'($urandom_range(0, 70)) - 35;
                    vy = int'($urandom_range(0, 70)) - 35;
                end
                2: begin
                    vx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(257, 400)) : 0;
                    vy = (vx == 0) ? -int'($urandom_range(257, 400)) : 0;
                    len = 1;
                end
                3: begin
                    vx = int'($urandom_range(0, 6)) - 3;
                    vy = int'($urandom_range(0, 6)) - 3;
                end
                default: begin
                    vx = ($urandom_range(0, 1) != 0) ? 24 : -24;
                    vy = ($urandom_range(0, 1) != 0) ? 24 : -24;
                end
            endcase
            for (int f = 0; f < len; f++) begin
                cx = clampc(cx + vx);
                cy = clampc(cy + vy);
                send(cx, cy, int'($urandom_range(0, 2)));
            end
        end
        for (int i = 0; i < 20; i++) send(cx, cy, 0);

        // Reset between E0 and E2 of a swing-terminating frame drops the pulse
        do_reset(1'b0);
        send(100, 100, 1); send(100, 100, 1);
        send(140, 100, 0); send(180, 100, 0); send(180, 100, 0);
        do_reset(1'b0);
        repeat (5) @(negedge clock);
        send(180, 100, 0); send(180, 100, 2);

        repeat (6) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 0);
        if (swings_seen < 3) begin
            vectors++; miscompares++;
            $display("FAIL swing_coverage: got %0d swings expected at least 3", swings_seen);
        end else begin
            vectors++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
